// File: rtl/cpld2_shift_selector.sv
// 5-bit working register updated each clock by one of eight select-driven operations,
// with a parity/popcount status word and a one-hot decode of the select.
module cpld2_shift_selector (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] left_in,
    input  logic [2:0] sel,
    output logic [3:0] sel_out,
    output logic [4:0] right_out,
    output logic [4:0] sel_decoded
);

    typedef enum logic [2:0] {
        OpHold   = 3'd0,
        OpLoad   = 3'd1,
        OpShr    = 3'd2,
        OpShl    = 3'd3,
        OpRor    = 3'd4,
        OpXor    = 3'd5,
        OpClear  = 3'd6,
        OpInvert = 3'd7
    } op_e;

    logic [4:0] r_q;
    logic [4:0] r_d;
    logic [2:0] ones;

    always_comb begin
        r_d = r_q;
        unique case (op_e'(sel))
            OpHold:   r_d = r_q;
            OpLoad:   r_d = left_in;
            OpShr:    r_d = {left_in[0], r_q[4:1]};
            OpShl:    r_d = {r_q[3:0], left_in[0]};
            OpRor:    r_d = {r_q[0], r_q[4:1]};
            OpXor:    r_d = r_q ^ left_in;
            OpClear:  r_d = 5'b00000;
            OpInvert: r_d = ~r_q;
            default:  r_d = r_q;
        endcase
    end

    // Reset wins over whatever operation is selected on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 5'b00000;
        end else begin
            r_q <= r_d;
        end
    end

    always_comb begin
        ones = 3'd0;
        for (int i = 0; i < 5; i++) begin
            ones = ones + {2'b00, r_q[i]};
        end
    end

    assign right_out = r_q;
    assign sel_out   = {^r_q, ones};

    // Only selects 0..4 have a decode bit; 5..7 decode to all zeros.
    always_comb begin
        sel_decoded = 5'b00000;
        if (sel < 3'd5) begin
            sel_decoded[sel] = 1'b1;
        end
    end

endmodule

// File: tb/tb_cpld2_shift_selector.sv
// Self-checking bench: directed literal checks plus randomized traffic against a
// behavioural model compared on every falling edge.
module tb_cpld2_shift_selector;

    logic       clk;
    logic       rst;
    logic [4:0] left_in;
    logic [2:0] sel;
    logic [3:0] sel_out;
    logic [4:0] right_out;
    logic [4:0] sel_decoded;

    int vectors;
    int miscompares;

    int  m_r;
    bit  m_valid;

    cpld2_shift_selector dut (
        .clk         (clk),
        .rst         (rst),
        .left_in     (left_in),
        .sel         (sel),
        .sel_out     (sel_out),
        .right_out   (right_out),
        .sel_decoded (sel_decoded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_status(input int r);
        int c;
        c = $countones(r[4:0]);
        return ((c % 2) * 8) + c;
    endfunction

    function automatic int model_decode(input int s);
        return (s < 5) ? (1 << s) : 0;
    endfunction

    // Reference model: next register value from arithmetic on integers.
    always @(posedge clk) begin
        int l0;
        l0 = int'(left_in) % 2;
        if (rst) begin
            m_r = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            case (int'(sel))
                0: m_r = m_r;
                1: m_r = int'(left_in);
                2: m_r = l0 * 16 + m_r / 2;
                3: m_r = (m_r * 2) % 32 + l0;
                4: m_r = (m_r % 2) * 16 + m_r / 2;
                5: m_r = m_r ^ int'(left_in);
                6: m_r = 0;
                default: m_r = 31 - m_r;
            endcase
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (int'(sel_decoded) != model_decode(int'(sel))) begin
            miscompares++;
            $display("FAIL cmp_sel_decoded t=%0t got=%b exp=%05b", $time, sel_decoded,
                     model_decode(int'(sel)));
        end
        if (m_valid) begin
            vectors++;
            if (int'(right_out) != m_r) begin
                miscompares++;
                $display("FAIL cmp_right_out t=%0t got=%b exp=%05b", $time, right_out, m_r);
            end
            vectors++;
            if (int'(sel_out) != model_status(m_r)) begin
                miscompares++;
                $display("FAIL cmp_sel_out t=%0t got=%b exp=%04b", $time, sel_out,
                         model_status(m_r));
            end
        end
    end

    task automatic chk(input string name, input logic [4:0] got, input logic [4:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%b exp=%b", name, got, exp);
        end
    endtask

    // Drive away from the edge, then return just after the capturing edge.
    task automatic op(input logic r, input logic [2:0] s, input logic [4:0] l);
        @(negedge clk);
        #2;
        rst = r;
        sel = s;
        left_in = l;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] shr_exp [5];
        vectors = 0;
        miscompares = 0;
        m_r = 0;
        m_valid = 1'b0;
        rst = 1'b1;
        sel = 3'd1;
        left_in = 5'b10101;
        shr_exp = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111};

        op(1'b1, 3'd1, 5'b10101);
        op(1'b1, 3'd1, 5'b10101);
        chk("reset_right_out", right_out, 5'b00000);
        chk("reset_sel_out", {1'b0, sel_out}, 5'b00000);
        chk("reset_sel_decoded", sel_decoded, 5'b00010);

        op(1'b0, 3'd1, 5'b10110);
        chk("load", right_out, 5'b10110);
        for (int i = 0; i < 3; i++) op(1'b0, 3'd0, 5'b01001);
        chk("hold", right_out, 5'b10110);
        chk("hold_status", {1'b0, sel_out}, 5'b01011);

        op(1'b0, 3'd6, 5'b11111);
        for (int i = 0; i < 5; i++) begin
            op(1'b0, 3'd2, 5'b00001);
            chk("shr_fill", right_out, shr_exp[i]);
        end
        chk("all_ones_status", {1'b0, sel_out}, 5'b01101);

        op(1'b0, 3'd1, 5'b10001);
        op(1'b0, 3'd3, 5'b11110);
        chk("shl", right_out, 5'b00010);
        op(1'b0, 3'd4, 5'b11111);
        chk("ror1", right_out, 5'b00001);
        op(1'b0, 3'd4, 5'b00000);
        chk("ror2", right_out, 5'b10000);
        for (int i = 0; i < 5; i++) op(1'b0, 3'd4, 5'b01010);
        chk("ror_wrap", right_out, 5'b10000);

        op(1'b0, 3'd1, 5'b01100);
        op(1'b0, 3'd5, 5'b01010);
        chk("xor", right_out, 5'b00110);
        op(1'b0, 3'd7, 5'b00000);
        chk("invert", right_out, 5'b11001);
        chk("invert_status", {1'b0, sel_out}, 5'b01011);
        op(1'b0, 3'd6, 5'b10101);
        chk("clear", right_out, 5'b00000);
        chk("clear_status", {1'b0, sel_out}, 5'b00000);

        for (int s = 0; s < 8; s++) begin
            op(1'b0, 3'(s), 5'b00000);
            chk("decode_sweep", sel_decoded, (s < 5) ? 5'(1 << s) : 5'b00000);
        end

        op(1'b0, 3'd1, 5'b00011);
        op(1'b0, 3'd7, 5'b00000);
        chk("inv_before_rst", right_out, 5'b11100);
        op(1'b1, 3'd7, 5'b00000);
        chk("rst_over_invert", right_out, 5'b00000);
        op(1'b0, 3'd7, 5'b00000);
        chk("inv_after_rst", right_out, 5'b11111);

        for (int i = 0; i < 400; i++) begin
            op(($urandom_range(15) == 0), 3'($urandom_range(7)), 5'($urandom_range(31)));
        end

        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
